// File: rtl/dmi_jtag_dtm_if.sv
`default_nettype none
// ==================================================================
// dmi_jtag_dtm_if : DMI request/response handshake bundle  (rev 1.0)
// ==================================================================
interface dmi_jtag_dtm_if #(
  parameter int AbitsWidth = 7
);
  logic                  req_valid;
  logic                  req_ready;
  logic [AbitsWidth-1:0] req_addr;
  logic [31:0]           req_data;
  logic [1:0]            req_op;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic [1:0]            resp_err;

  modport master (
    output req_valid, req_addr, req_data, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/dmi_jtag_dtm.sv
`default_nettype none
// ==================================================================
// dmi_jtag_dtm : JTAG DTM dtmcs/dmi registers and DMI handshake engine  (rev 1.0)
// ==================================================================
module dmi_jtag_dtm #(
  parameter int AbitsWidth    = 7,
  parameter int IdleHint      = 1,
  parameter int TimeoutCycles = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           test_logic_reset_i,
  input  logic           capture_dr_i,
  input  logic           shift_dr_i,
  input  logic           update_dr_i,
  input  logic           dmi_select_i,
  input  logic           dtmcs_select_i,
  input  logic           tdi_i,
  output logic           tdo_o,
  dmi_jtag_dtm_if.master dmi,
  output logic [1:0]     dmi_error_o
);

  localparam int         c_dr_width   = AbitsWidth + 34;
  localparam int         c_cnt_width  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [2:0] c_idle_hint  = 3'(IdleHint);
  localparam logic [5:0] c_abits      = 6'(AbitsWidth);
  localparam logic [1:0] c_op_read    = 2'd1;
  localparam logic [1:0] c_op_write   = 2'd2;
  localparam logic [1:0] c_err_none   = 2'd0;
  localparam logic [1:0] c_err_failed = 2'd2;
  localparam logic [1:0] c_err_busy   = 2'd3;

  typedef enum logic [1:0] {StIdle, StReq, StWaitResp} state_e;
  typedef logic [c_cnt_width-1:0] cnt_t;

  state_e                  state_q, state_d;
  logic [c_dr_width-1:0]   shift_q, shift_d;
  logic [AbitsWidth-1:0]   addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic [1:0]              op_q, op_d;
  logic [1:0]              error_q, error_d;
  cnt_t                    cnt_q, cnt_d;
  logic                    discard_q, discard_d;

  logic                    w_busy;
  logic                    w_dmi_update;
  logic                    w_dtmcs_update;
  logic                    w_timeout;
  logic [31:0]             w_dtmcs;
  logic [AbitsWidth-1:0]   w_dr_addr;
  logic [31:0]             w_dr_data;
  logic [1:0]              w_dr_op;

  assign w_dmi_update   = update_dr_i && dmi_select_i;
  assign w_dtmcs_update = update_dr_i && dtmcs_select_i;
  assign w_busy         = (update_dr_i || capture_dr_i) && dmi_select_i && (state_q != StIdle);
  assign w_dtmcs        = {14'b0, 1'b0, 1'b0, 1'b0, c_idle_hint, error_q, c_abits, 4'd1};
  assign w_dr_addr      = shift_q[c_dr_width-1:34];
  assign w_dr_data      = shift_q[33:2];
  assign w_dr_op        = shift_q[1:0];

  if (TimeoutCycles > 0) begin : g_timeout
    assign w_timeout = (cnt_q == cnt_t'(TimeoutCycles - 1));
  end else begin : g_no_timeout
    assign w_timeout = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_q      <= '0;
      error_q   <= c_err_none;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_q      <= op_d;
      error_q   <= error_d;
      cnt_q     <= cnt_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    data_d    = data_q;
    op_d      = op_q;
    error_d   = error_q;
    cnt_d     = cnt_q;
    discard_d = discard_q;

    // dtmcs only occupies the low 32 bits of the shared shift register
    if (test_logic_reset_i) begin
      shift_d = '0;
    end else if (capture_dr_i && dmi_select_i) begin
      shift_d = {addr_q, data_q, w_busy ? c_err_busy : error_q};
    end else if (capture_dr_i && dtmcs_select_i) begin
      shift_d[31:0] = w_dtmcs;
    end else if (shift_dr_i && dmi_select_i) begin
      shift_d = {tdi_i, shift_q[c_dr_width-1:1]};
    end else if (shift_dr_i && dtmcs_select_i) begin
      shift_d[31:0] = {tdi_i, shift_q[31:1]};
    end

    case (state_q)
      StIdle: begin
        if (discard_q && dmi.resp_valid) begin
          discard_d = 1'b0;
        end
        if (w_dmi_update && (error_q == c_err_none)) begin
          addr_d = w_dr_addr;
          data_d = w_dr_data;
          if (((w_dr_op == c_op_read) || (w_dr_op == c_op_write)) && !discard_q) begin
            op_d    = w_dr_op;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (dmi.req_ready) begin
          state_d = StWaitResp;
          cnt_d   = '0;
        end
      end
      StWaitResp: begin
        if (dmi.resp_valid) begin
          state_d = StIdle;
          if ((op_q == c_op_read) && (dmi.resp_err == c_err_none)) begin
            data_d = dmi.resp_data;
          end
          if ((error_q == c_err_none) &&
              ((dmi.resp_err == c_err_failed) || (dmi.resp_err == c_err_busy))) begin
            error_d = dmi.resp_err;
          end
        end else if (w_timeout) begin
          state_d   = StIdle;
          discard_d = 1'b1;
          if (error_q == c_err_none) begin
            error_d = c_err_failed;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (w_busy && (error_q == c_err_none)) begin
      error_d = c_err_busy;
    end

    // A request already handed off (or in flight) leaves a response to swallow
    if (w_dtmcs_update) begin
      if (shift_q[16]) begin
        error_d = c_err_none;
      end
      if (shift_q[17]) begin
        error_d = c_err_none;
        state_d = StIdle;
        if (((state_q == StWaitResp) && !dmi.resp_valid) ||
            ((state_q == StReq) && dmi.req_ready)) begin
          discard_d = 1'b1;
        end
      end
    end
  end

  assign tdo_o          = shift_q[0];
  assign dmi_error_o    = error_q;
  assign dmi.req_valid  = (state_q == StReq);
  assign dmi.req_addr   = addr_q;
  assign dmi.req_data   = data_q;
  assign dmi.req_op     = op_q;
  assign dmi.resp_ready = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_dmi_jtag_dtm.sv
`default_nettype none
// ==================================================================
// tb_dmi_jtag_dtm : directed bench for dmi_jtag_dtm (AbitsWidth=9, timeout 8)  (rev 1.0)
// ==================================================================
module tb_dmi_jtag_dtm;

  localparam int c_abits = 9;
  localparam int c_drw   = c_abits + 34;

  logic       clk;
  logic       rst;
  logic       tlr;
  logic       cap;
  logic       sh;
  logic       upd;
  logic       dmi_sel;
  logic       dtmcs_sel;
  logic       tdi;
  logic       tdo;
  logic [1:0] dmi_error;

  int n_total = 0;
  int n_bad   = 0;

  logic [c_drw-1:0] d;
  logic [31:0]      d32;

  dmi_jtag_dtm_if #(.AbitsWidth(c_abits)) bus ();

  dmi_jtag_dtm #(
    .AbitsWidth    (c_abits),
    .IdleHint      (5),
    .TimeoutCycles (8)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .test_logic_reset_i (tlr),
    .capture_dr_i       (cap),
    .shift_dr_i         (sh),
    .update_dr_i        (upd),
    .dmi_select_i       (dmi_sel),
    .dtmcs_select_i     (dtmcs_sel),
    .tdi_i              (tdi),
    .tdo_o              (tdo),
    .dmi                (bus),
    .dmi_error_o        (dmi_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic scan_dmi(input logic [c_drw-1:0] din, output logic [c_drw-1:0] dout);
    dmi_sel = 1'b1;
    cap     = 1'b1;
    tick();
    cap = 1'b0;
    sh  = 1'b1;
    for (int i = 0; i < c_drw; i++) begin
      dout[i] = tdo;
      tdi     = din[i];
      tick();
    end
    sh  = 1'b0;
    upd = 1'b1;
    tick();
    upd     = 1'b0;
    dmi_sel = 1'b0;
  endtask

  task automatic scan_dtmcs(input logic [31:0] din, output logic [31:0] dout);
    dtmcs_sel = 1'b1;
    cap       = 1'b1;
    tick();
    cap = 1'b0;
    sh  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dout[i] = tdo;
      tdi     = din[i];
      tick();
    end
    sh  = 1'b0;
    upd = 1'b1;
    tick();
    upd       = 1'b0;
    dtmcs_sel = 1'b0;
  endtask

  task automatic pulse_dmi_update();
    dmi_sel = 1'b1;
    upd     = 1'b1;
    tick();
    upd     = 1'b0;
    dmi_sel = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic [1:0] err);
    bus.resp_valid = 1'b1;
    bus.resp_data  = data;
    bus.resp_err   = err;
    tick();
    bus.resp_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tlr = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b0;
    dmi_sel = 1'b0; dtmcs_sel = 1'b0; tdi = 1'b0;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
    bus.resp_data = '0; bus.resp_err = '0;
    tick();
    tick();
    chk("rst_tdo",        tdo, 0);
    chk("rst_valid",      bus.req_valid, 0);
    chk("rst_error",      dmi_error, 0);
    chk("rst_resp_ready", bus.resp_ready, 1);
    rst = 1'b0;
    tick();

    // test-logic-reset wipes the shift register
    dtmcs_sel = 1'b1; cap = 1'b1;
    tick();
    cap = 1'b0;
    chk("dtmcs_cap_tdo", tdo, 1);
    tlr = 1'b1;
    tick();
    tlr = 1'b0; dtmcs_sel = 1'b0;
    chk("tlr_tdo", tdo, 0);

    // write, immediate ready
    bus.req_ready = 1'b1;
    scan_dmi({9'h010, 32'hDEADBEEF, 2'd2}, d);
    chk("wr_cap", d, 0);
    chk("wr_valid", bus.req_valid, 1);
    chk("wr_addr", bus.req_addr, 9'h010);
    chk("wr_data", bus.req_data, 32'hDEADBEEF);
    chk("wr_op", bus.req_op, 2);
    tick();
    chk("wr_valid_drop", bus.req_valid, 0);
    respond(32'hAAAA5555, 2'd0);
    scan_dmi('0, d);
    chk("wr_recap", d, {9'h010, 32'hDEADBEEF, 2'd0});
    chk("nop_no_req", bus.req_valid, 0);

    // read
    scan_dmi({9'h004, 32'h0, 2'd1}, d);
    chk("rd_valid", bus.req_valid, 1);
    chk("rd_op", bus.req_op, 1);
    chk("rd_addr", bus.req_addr, 9'h004);
    tick();
    respond(32'h12345678, 2'd0);
    scan_dmi('0, d);
    chk("rd_recap", d, {9'h004, 32'h12345678, 2'd0});

    // busy: update while waiting for the response, then a failing response stays masked
    scan_dmi({9'h155, 32'h0, 2'd1}, d);
    tick();
    pulse_dmi_update();
    chk("busy_err", dmi_error, 3);
    chk("busy_no_req", bus.req_valid, 0);
    respond(32'h11112222, 2'd2);
    chk("busy_sticky", dmi_error, 3);
    scan_dmi({9'h0FF, 32'hCAFEF00D, 2'd2}, d);
    chk("busy_cap", d, {9'h155, 32'h0, 2'd3});
    chk("busy_upd_ignored", bus.req_valid, 0);
    scan_dtmcs(32'h0001_0000, d32);
    chk("dtmcs_busy", d32, 32'h0000_5C91);
    chk("dmireset_err", dmi_error, 0);
    scan_dmi({9'h0FF, 32'hCAFEF00D, 2'd2}, d);
    chk("after_reset_cap", d, {9'h155, 32'h0, 2'd0});
    chk("after_reset_valid", bus.req_valid, 1);
    chk("after_reset_data", bus.req_data, 32'hCAFEF00D);
    tick();
    respond(32'h99999999, 2'd0);

    // read failing with err 2, a later err 3 does not replace it
    scan_dmi({9'h003, 32'h5A5A5A5A, 2'd1}, d);
    chk("err_cap", d, {9'h0FF, 32'hCAFEF00D, 2'd0});
    tick();
    respond(32'hFFFFFFFF, 2'd2);
    chk("err2", dmi_error, 2);
    respond(32'h0, 2'd3);
    chk("err2_kept", dmi_error, 2);
    scan_dmi('0, d);
    chk("err_data_kept", d, {9'h003, 32'h5A5A5A5A, 2'd2});

    // timeout after eight cycles in WaitResp
    scan_dtmcs(32'h0001_0000, d32);
    chk("dtmcs_err2", d32, 32'h0000_5891);
    chk("clear2", dmi_error, 0);
    scan_dmi({9'h1AB, 32'h0BADF00D, 2'd1}, d);
    chk("to_cap", d, {9'h003, 32'h5A5A5A5A, 2'd0});
    chk("to_valid", bus.req_valid, 1);
    tick();
    repeat (7) tick();
    chk("to_not_yet", dmi_error, 0);
    tick();
    chk("to_err", dmi_error, 2);
    scan_dtmcs(32'h0001_0000, d32);
    chk("to_clear", dmi_error, 0);
    scan_dmi({9'h0C3, 32'h0, 2'd1}, d);
    chk("to_data_kept", d, {9'h1AB, 32'h0BADF00D, 2'd0});
    chk("discard_block", bus.req_valid, 0);
    respond(32'hFFFF0000, 2'd0);
    scan_dmi({9'h0C3, 32'h0, 2'd1}, d);
    chk("late_ignored", d, {9'h0C3, 32'h0, 2'd0});
    chk("post_discard_valid", bus.req_valid, 1);
    tick();
    respond(32'h0F0F0F0F, 2'd0);

    // hardreset while a request waits for ready
    bus.req_ready = 1'b0;
    scan_dmi({9'h022, 32'h0000_0001, 2'd2}, d);
    chk("hr_cap", d, {9'h0C3, 32'h0F0F0F0F, 2'd0});
    tick();
    chk("hr_hold_valid", bus.req_valid, 1);
    chk("hr_hold_addr", bus.req_addr, 9'h022);
    pulse_dmi_update();
    chk("hr_busy", dmi_error, 3);
    scan_dtmcs(32'h0002_0000, d32);
    chk("hr_dtmcs", d32, 32'h0000_5C91);
    chk("hr_valid_drop", bus.req_valid, 0);
    chk("hr_err_clear", dmi_error, 0);
    bus.req_ready = 1'b1;
    tick();
    chk("hr_stay_idle", bus.req_valid, 0);
    scan_dmi('0, d);
    chk("hr_recap", d, {9'h022, 32'h0000_0001, 2'd0});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
